// File: rtl/demux_pkg.sv
// Shared constants and channel-index type for the 1-to-4 registered demultiplexer.
package demux_pkg;

  localparam int unsigned NOUT  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef logic [SEL_W-1:0] chan_t;

  // One-hot decode of a channel index.
  function automatic logic [NOUT-1:0] sel_decode(input chan_t sel);
    return NOUT'(1) << sel;
  endfunction

endpackage

// File: rtl/demux4_4_reg_if.sv
// Handshake/data bundle for demux4_4_reg; cnt0..cnt3 exist only when DEMUX_COUNT_EN is defined.
interface demux4_4_reg_if #(
  parameter int unsigned WIDTH = 4
);
  import demux_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  chan_t                in_sel;
  logic [WIDTH-1:0]     in_data;
  logic [NOUT-1:0]      out_valid;
  logic [NOUT-1:0]      out_ready;
  logic [WIDTH-1:0]     out_data0;
  logic [WIDTH-1:0]     out_data1;
  logic [WIDTH-1:0]     out_data2;
  logic [WIDTH-1:0]     out_data3;
`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0]     cnt0;
  logic [CNT_W-1:0]     cnt1;
  logic [CNT_W-1:0]     cnt2;
  logic [CNT_W-1:0]     cnt3;
`endif

  // Demux side: consumes the input word, produces the four channels.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
`ifdef DEMUX_COUNT_EN
    , output cnt0, cnt1, cnt2, cnt3
`endif
  );

  // Environment side: offers input words and consumes channel outputs.
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
`ifdef DEMUX_COUNT_EN
    , input cnt0, cnt1, cnt2, cnt3
`endif
  );

endinterface

// File: rtl/demux_slot.sv
// One output channel: full flag, data register, load/drain logic and an optional
// saturating delivery counter (DEMUX_COUNT_EN).
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic             full,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  logic drain_c;

  assign drain_c = full && out_ready;

  // A load on the same edge as a drain wins, so the slot stays full with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= din;
    end else if (drain_c) begin
      full <= 1'b0;
    end
  end

`ifdef DEMUX_COUNT_EN
  // Delivered-word counter, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (drain_c && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/demux4_4_reg.sv
// 1-to-4 registered demultiplexer with per-channel valid/ready handshake.
// Optional per-channel delivery counters are compiled in with DEMUX_COUNT_EN.
module demux4_4_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  demux4_4_reg_if.slave  bus
);

  logic [NOUT-1:0]  full;
  logic [NOUT-1:0]  sel_oh;
  logic [NOUT-1:0]  load;
  logic             in_ready_c;
  logic [WIDTH-1:0] slot_data [NOUT];
`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] slot_cnt  [NOUT];
`endif

  // Ready follows the addressed slot only; never looks at in_valid.
  assign sel_oh     = sel_decode(bus.in_sel);
  assign in_ready_c = !full[bus.in_sel] || bus.out_ready[bus.in_sel];
  assign load       = sel_oh & {NOUT{bus.in_valid && in_ready_c}};

  for (genvar i = 0; i < NOUT; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .din       (bus.in_data),
      .out_ready (bus.out_ready[i]),
      .full      (full[i]),
      .data      (slot_data[i])
`ifdef DEMUX_COUNT_EN
      ,
      .cnt       (slot_cnt[i])
`endif
    );
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = full;
  assign bus.out_data0 = slot_data[0];
  assign bus.out_data1 = slot_data[1];
  assign bus.out_data2 = slot_data[2];
  assign bus.out_data3 = slot_data[3];
`ifdef DEMUX_COUNT_EN
  assign bus.cnt0 = slot_cnt[0];
  assign bus.cnt1 = slot_cnt[1];
  assign bus.cnt2 = slot_cnt[2];
  assign bus.cnt3 = slot_cnt[3];
`endif

endmodule

// File: doc/demux4_4_reg.md
DEMUX4_4_REG -- requirements
Module: demux4_4_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: data width of the input and of each output channel.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the input word is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-006 The block SHALL have port in_sel, input, 2 bits: destination channel 0..3.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: input word.
REQ-008 The block SHALL have ports out_valid and out_ready, output and input respectively, 4 bits each: per-channel handshake, where bit i is channel i.
REQ-009 The block SHALL have ports out_data0..out_data3, output, WIDTH bits each: per-channel data.
REQ-010 When DEMUX_COUNT_EN is defined, the block SHALL have ports cnt0..cnt3, output, 8 bits each: per-channel delivered-word counters.

Function
REQ-011 The block SHALL hold one storage slot per channel, each with a full flag and a WIDTH-bit data register.
REQ-012 in_ready SHALL equal (!full[in_sel] || out_ready[in_sel]), depend only on current state, in_sel and out_ready, and never depend on in_valid.
REQ-013 An input transfer SHALL occur on a rising clk edge where in_valid && in_ready, loading in_data into slot in_sel and setting full[in_sel].
REQ-014 Latency SHALL be exactly 1 cycle: out_valid[s] and out_data<s> reflect the word in the cycle after acceptance.
REQ-015 out_valid[i] SHALL equal full[i], and out_data<i> SHALL be driven directly from the slot register of channel i.
REQ-016 An output transfer on channel i SHALL occur on an edge where out_valid[i] && out_ready[i], clearing full[i] unless the same edge refills channel i.
REQ-017 For a simultaneous drain and refill of the same channel, the new word SHALL be loaded, full SHALL remain 1, and no bubble SHALL be inserted.
REQ-018 While out_valid[i] && !out_ready[i], out_data<i> SHALL hold stable.
REQ-019 Channels not addressed by in_sel SHALL never be modified by an input transfer, and all four channels SHALL drain independently in the same cycle.
REQ-020 An empty slot SHALL retain its last data value, and out_data<i> is don't-care to consumers while out_valid[i]=0.
REQ-021 A change of in_sel while in_valid && !in_ready SHALL be permitted, with in_ready re-evaluated for the new channel.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately, without a clock, clear all full flags, all slot data, and (if compiled in) all counters to 0.
REQ-023 Reset asserted mid-operation SHALL discard buffered words, with no output handshake reported for them.
REQ-024 While rst_n=0, out_valid SHALL be 4'b0000, in_ready SHALL be 1, and no transfer SHALL occur.
REQ-025 The first transfer SHALL be possible on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 With macro DEMUX_COUNT_EN defined, cnt<i> SHALL increment by 1 on each output transfer of channel i, saturate at 255 and not wrap; with it undefined, the counter logic and the cnt ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Shared package demux_pkg SHALL hold NOUT=4, SEL_W=2, CNT_W=8, and the channel-index type.
REQ-028 One sub-module demux_slot SHALL implement one channel (full flag, data register, load/drain logic, optional counter) and SHALL be instantiated four times.
REQ-029 The top level SHALL contain only in_sel decode, in_ready mux, and port wiring.

Verification
REQ-030 Bench: reset, then in_sel=2, in_data=4'hA, in_valid=1 for 1 cycle, out_ready=4'b1111 -> next cycle out_valid=4'b0100 and out_data2=4'hA; following cycle out_valid=0.
REQ-031 Bench: out_ready=0, write ch1=4'h3 then ch1=4'h5 -> second word stalls with in_ready=0 and out_data1 stays 4'h3; raise out_ready[1] -> 4'h3 drains and 4'h5 is accepted on the same edge, out_valid[1] stays 1, and 4'h5 appears next cycle.
REQ-032 Bench: all four channels full, out_ready=0, then out_ready=4'b1111 for 1 cycle -> all out_valid drop together, and in_ready=1 for every in_sel.
REQ-033 Bench: streaming, in_sel cycling 0,1,2,3 every cycle with out_ready=4'b1111 -> one word accepted per cycle, in_ready never 0, and each word appears on the correct channel 1 cycle later.
REQ-034 Bench: rst_n pulsed low mid-stream between clock edges -> out_valid=0 immediately, and the next accepted word is delivered normally.
REQ-035 Bench (DEMUX_COUNT_EN): 300 deliveries on ch0 -> cnt0=255 and cnt1..cnt3=0; reset -> cnt0=0.
